// File: rtl/jtag_pkg.sv
// Shared TAP state encoding and opcode map for the multi-register JTAG slow-control port.
package jtag_pkg;

   typedef enum logic [3:0] {
      ST_TLR      = 4'd0,
      ST_RTI      = 4'd1,
      ST_SEL_DR   = 4'd2,
      ST_CAP_DR   = 4'd3,
      ST_SH_DR    = 4'd4,
      ST_EX1_DR   = 4'd5,
      ST_PAUSE_DR = 4'd6,
      ST_EX2_DR   = 4'd7,
      ST_UPD_DR   = 4'd8,
      ST_SEL_IR   = 4'd9,
      ST_CAP_IR   = 4'd10,
      ST_SH_IR    = 4'd11,
      ST_EX1_IR   = 4'd12,
      ST_PAUSE_IR = 4'd13,
      ST_EX2_IR   = 4'd14,
      ST_UPD_IR   = 4'd15
   } tap_state_t;

   localparam int IDCODE_LEN = 32;

   function automatic int op_sts(int k);
      return 2 * k;
   endfunction

   function automatic int op_cfg(int k);
      return 2 * k + 1;
   endfunction

   function automatic int op_idcode(int irw);
      return (1 << irw) - 2;
   endfunction

   function automatic int op_bypass(int irw);
      return (1 << irw) - 1;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: tms walks the 16-state machine, with registered state decodes.
//
// state     | meaning
// TLR       | test logic reset, IR forced to IDCODE
// RTI       | run-test/idle, hard_rst landing state
// SEL_DR/IR | column select
// CAP_DR/IR | parallel load of the shift register
// SH_DR/IR  | shift one bit per tck, tdo driven
// EX1/EX2   | exit states around pause
// PAUSE     | hold shift register and bit count
// UPD_DR/IR | commit shift register to target
import jtag_pkg::*;

module jtag_tap_fsm (
   input  logic       tck,
   input  logic       hard_rst,
   input  logic       tms,
   output logic [3:0] jstate,
   output logic       tlr,
   output logic       cap_dr,
   output logic       sh_dr,
   output logic       upd_dr,
   output logic       cap_ir,
   output logic       sh_ir,
   output logic       upd_ir
);

   tap_state_t state;
   tap_state_t nxt;

   function automatic tap_state_t next_state(tap_state_t s, logic t);
      tap_state_t n;
      n = ST_RTI;
      case (s)
         ST_TLR:      n = t ? ST_TLR      : ST_RTI;
         ST_RTI:      n = t ? ST_SEL_DR   : ST_RTI;
         ST_SEL_DR:   n = t ? ST_SEL_IR   : ST_CAP_DR;
         ST_CAP_DR:   n = t ? ST_EX1_DR   : ST_SH_DR;
         ST_SH_DR:    n = t ? ST_EX1_DR   : ST_SH_DR;
         ST_EX1_DR:   n = t ? ST_UPD_DR   : ST_PAUSE_DR;
         ST_PAUSE_DR: n = t ? ST_EX2_DR   : ST_PAUSE_DR;
         ST_EX2_DR:   n = t ? ST_UPD_DR   : ST_SH_DR;
         ST_UPD_DR:   n = t ? ST_SEL_DR   : ST_RTI;
         ST_SEL_IR:   n = t ? ST_TLR      : ST_CAP_IR;
         ST_CAP_IR:   n = t ? ST_EX1_IR   : ST_SH_IR;
         ST_SH_IR:    n = t ? ST_EX1_IR   : ST_SH_IR;
         ST_EX1_IR:   n = t ? ST_UPD_IR   : ST_PAUSE_IR;
         ST_PAUSE_IR: n = t ? ST_EX2_IR   : ST_PAUSE_IR;
         ST_EX2_IR:   n = t ? ST_UPD_IR   : ST_SH_IR;
         ST_UPD_IR:   n = t ? ST_SEL_DR   : ST_RTI;
         default:     n = ST_RTI;
      endcase
      return n;
   endfunction

   always_comb begin
      nxt = next_state(state, tms);
   end

   // Decodes are registered from the next state so they line up with state itself.
   always_ff @(posedge tck or negedge hard_rst) begin
      if (!hard_rst) begin
         state  <= ST_RTI;
         jstate <= ~ST_RTI;
         tlr    <= 1'b0;
         cap_dr <= 1'b0;
         sh_dr  <= 1'b0;
         upd_dr <= 1'b0;
         cap_ir <= 1'b0;
         sh_ir  <= 1'b0;
         upd_ir <= 1'b0;
      end else begin
         state  <= nxt;
         jstate <= ~nxt;
         tlr    <= (nxt == ST_TLR);
         cap_dr <= (nxt == ST_CAP_DR);
         sh_dr  <= (nxt == ST_SH_DR);
         upd_dr <= (nxt == ST_UPD_DR);
         cap_ir <= (nxt == ST_CAP_IR);
         sh_ir  <= (nxt == ST_SH_IR);
         upd_ir <= (nxt == ST_UPD_IR);
      end
   end

endmodule

// File: rtl/jtag_tap_multireg.sv
// JTAG slow-control port: IR, length-checked DR scans into NREG config registers,
// capture-only status registers, IDCODE and BYPASS.
import jtag_pkg::*;

module jtag_tap_multireg #(
   parameter int                   IRW      = 5,
   parameter int                   NREG     = 4,
   parameter int                   RW       = 32,
   parameter logic [31:0]          IDCODE   = 32'h0A1C_0288,
   parameter logic [NREG*RW-1:0]   CFG_INIT = '0,
   parameter logic [NREG-1:0]      WMASK    = '1,
   parameter bit                   TLR_CLR  = 1'b0
) (
   input  logic                 tck,
   input  logic                 hard_rst,
   input  logic                 tms,
   input  logic                 tdi,
   output logic                 tdo,
   output logic                 tdo_oe,
   output logic [3:0]           jstate,
   output logic [NREG*RW-1:0]   cfg_q,
   output logic [NREG-1:0]      cfg_upd,
   input  logic [NREG*RW-1:0]   sts_d,
   output logic                 len_err
);

   localparam int L  = (RW > IDCODE_LEN) ? RW : IDCODE_LEN;
   localparam int CW = $clog2(L + 2);
   localparam logic [IRW-1:0] OP_ID = IRW'(op_idcode(IRW));

   logic tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

   logic [IRW-1:0]  ir;
   logic [IRW-1:0]  ir_sr;
   logic [L-1:0]    dr_sr;
   logic [L-1:0]    dr_next;
   logic [L-1:0]    dr_sh;
   logic [L-1:0]    cap_val;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   len;
   logic            is_cfg;
   logic [NREG-1:0] cfg_sel;

   jtag_tap_fsm u_fsm (
      .tck      (tck),
      .hard_rst (hard_rst),
      .tms      (tms),
      .jstate   (jstate),
      .tlr      (tlr),
      .cap_dr   (cap_dr),
      .sh_dr    (sh_dr),
      .upd_dr   (upd_dr),
      .cap_ir   (cap_ir),
      .sh_ir    (sh_ir),
      .upd_ir   (upd_ir)
   );

   // Unlisted opcodes fall through to the 1-bit bypass defaults.
   always_comb begin
      is_cfg  = 1'b0;
      cfg_sel = '0;
      cap_val = '0;
      len     = CW'(1);
      if (ir == OP_ID) begin
         len                      = CW'(IDCODE_LEN);
         cap_val[IDCODE_LEN-1:0]  = IDCODE;
      end
      for (int k = 0; k < NREG; k++) begin
         if (ir == IRW'(op_sts(k))) begin
            len              = CW'(RW);
            cap_val[RW-1:0]  = sts_d[k*RW +: RW];
         end
         if (ir == IRW'(op_cfg(k))) begin
            len              = CW'(RW);
            cap_val[RW-1:0]  = cfg_q[k*RW +: RW];
            is_cfg           = 1'b1;
            cfg_sel[k]       = 1'b1;
         end
      end
   end

   // Only the selected len bits move; tdi enters at bit len-1.
   always_comb begin
      dr_sh   = dr_sr >> 1;
      dr_next = dr_sr;
      for (int i = 0; i < L; i++) begin
         if (i == int'(len) - 1)
            dr_next[i] = tdi;
         else if (i < int'(len) - 1)
            dr_next[i] = dr_sh[i];
      end
   end

   always_ff @(posedge tck or negedge hard_rst) begin
      if (!hard_rst) begin
         ir      <= OP_ID;
         ir_sr   <= '0;
         dr_sr   <= '0;
         cnt     <= '0;
         cfg_q   <= CFG_INIT;
         cfg_upd <= '0;
         len_err <= 1'b0;
      end else begin
         cfg_upd <= '0;
         if (tlr) begin
            ir      <= OP_ID;
            len_err <= 1'b0;
            if (TLR_CLR)
               cfg_q <= CFG_INIT;
         end
         if (cap_ir)
            ir_sr <= IRW'(1);
         if (sh_ir)
            ir_sr <= {tdi, ir_sr[IRW-1:1]};
         if (upd_ir)
            ir <= ir_sr;
         if (cap_dr) begin
            dr_sr <= cap_val;
            cnt   <= '0;
         end
         if (sh_dr) begin
            dr_sr <= dr_next;
            if (cnt != len + CW'(1))
               cnt <= cnt + CW'(1);
         end
         // Length is enforced only on config writes; a short or long scan never lands.
         if (upd_dr && is_cfg) begin
            if (cnt == len) begin
               for (int k = 0; k < NREG; k++) begin
                  if (cfg_sel[k] && WMASK[k]) begin
                     cfg_q[k*RW +: RW] <= dr_sr[RW-1:0];
                     cfg_upd[k]        <= 1'b1;
                  end
               end
            end else begin
               len_err <= 1'b1;
            end
         end
      end
   end

   always_ff @(negedge tck or negedge hard_rst) begin
      if (!hard_rst) begin
         tdo    <= 1'b0;
         tdo_oe <= 1'b0;
      end else begin
         tdo_oe <= sh_dr | sh_ir;
         if (sh_dr)
            tdo <= dr_sr[0];
         else if (sh_ir)
            tdo <= ir_sr[0];
      end
   end

endmodule

// File: tb/tb_jtag_tap_multireg.sv
// Bench for jtag_tap_multireg: directed vector table, async-reset sequence, and
// randomized scans against a transaction-level register model.
module tb_jtag_tap_multireg;

   localparam int IRW  = 5;
   localparam int NREG = 4;
   localparam int RW   = 32;
   localparam logic [31:0]     IDC = 32'h0A1C_0288;
   localparam logic [NREG-1:0] WM  = 4'b1011;

   logic                 tck = 1'b0;
   logic                 hard_rst = 1'b0;
   logic                 tms = 1'b0;
   logic                 tdi = 1'b0;
   logic                 tdo;
   logic                 tdo_oe;
   logic [3:0]           jstate;
   logic [NREG*RW-1:0]   cfg_q;
   logic [NREG-1:0]      cfg_upd;
   logic [NREG*RW-1:0]   sts_d = '0;
   logic                 len_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] cfg_m [NREG];
   logic [31:0] sts_m [NREG];
   logic        err_m;

   typedef struct {
      bit           do_tlr;
      bit           skip_ir;
      int           op;
      int           n;
      int           pause_at;
      logic [63:0]  data;
      logic [63:0]  exp_out;
      logic         exp_err;
      logic [3:0]   exp_upd;
      logic [127:0] exp_cfg;
   } vec_t;

   vec_t tv [14];

   jtag_tap_multireg #(
      .IRW      (IRW),
      .NREG     (NREG),
      .RW       (RW),
      .IDCODE   (IDC),
      .CFG_INIT ('0),
      .WMASK    (WM),
      .TLR_CLR  (1'b0)
   ) dut (
      .tck      (tck),
      .hard_rst (hard_rst),
      .tms      (tms),
      .tdi      (tdi),
      .tdo      (tdo),
      .tdo_oe   (tdo_oe),
      .jstate   (jstate),
      .cfg_q    (cfg_q),
      .cfg_upd  (cfg_upd),
      .sts_d    (sts_d),
      .len_err  (len_err)
   );

   always #5 tck = ~tck;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, actual=running required=finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive tms/tdi between edges and return tdo as seen by the coming posedge.
   task automatic step(input logic t, input logic d, output logic o);
      @(negedge tck);
      #1;
      tms = t;
      tdi = d;
      o   = tdo;
      @(posedge tck);
      #1;
   endtask

   task automatic tlr_reset();
      logic o;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, o);
      step(1'b0, 1'b0, o);
   endtask

   task automatic ir_scan(input logic [IRW-1:0] op, output logic [IRW-1:0] cap);
      logic o;
      step(1'b1, 1'b0, o);
      step(1'b1, 1'b0, o);
      step(1'b0, 1'b0, o);
      step(1'b0, 1'b0, o);
      for (int i = 0; i < IRW; i++) begin
         step(i == IRW - 1, op[i], o);
         cap[i] = o;
      end
      step(1'b1, 1'b0, o);
      step(1'b0, 1'b0, o);
   endtask

   task automatic dr_scan(input int n, input logic [63:0] data, input int pause_at,
                          output logic [63:0] out, output logic [3:0] upd);
      logic o;
      logic brk;
      out = '0;
      step(1'b1, 1'b0, o);
      step(1'b0, 1'b0, o);
      if (n == 0) begin
         step(1'b1, 1'b0, o);
      end else begin
         step(1'b0, 1'b0, o);
         for (int i = 0; i < n; i++) begin
            brk = (pause_at != 0) && (i == pause_at - 1) && (i != n - 1);
            step((i == n - 1) || brk, data[i], o);
            out[i] = o;
            if (brk) begin
               step(1'b0, 1'b0, o);
               step(1'b0, 1'b0, o);
               step(1'b1, 1'b0, o);
               step(1'b0, 1'b0, o);
            end
         end
      end
      step(1'b1, 1'b0, o);
      step(1'b0, 1'b0, o);
      upd = cfg_upd;
   endtask

   // Register-level view: the DR is a FIFO of len captured bits followed by tdi.
   task automatic model_scan(input int op, input int n, input logic [63:0] data,
                             output logic [63:0] eo, output logic [3:0] eu);
      int len;
      int k;
      logic [31:0] cap;
      k = op / 2;
      if (op < 2 * NREG) begin
         len = RW;
         cap = (op % 2 == 1) ? cfg_m[k] : sts_m[k];
      end else if (op == 30) begin
         len = 32;
         cap = IDC;
      end else begin
         len = 1;
         cap = 32'h0;
      end
      eo = '0;
      for (int i = 0; i < n; i++) eo[i] = (i < len) ? cap[i] : data[i - len];
      eu = '0;
      if (op < 2 * NREG && op % 2 == 1) begin
         if (n == len) begin
            if (WM[k]) begin
               cfg_m[k] = data[31:0];
               eu[k]    = 1'b1;
            end
         end else begin
            err_m = 1'b1;
         end
      end
   endtask

   function automatic logic [127:0] cfg_flat();
      return {cfg_m[3], cfg_m[2], cfg_m[1], cfg_m[0]};
   endfunction

   function automatic logic [63:0] nmask(input int n);
      return (n == 0) ? 64'h0 : ((64'h1 << n) - 64'h1);
   endfunction

   function automatic vec_t mk(input bit tl, input bit sk, input int op, input int n, input int p,
                               input logic [63:0] d, input logic [63:0] eo, input logic ee,
                               input logic [3:0] eu, input logic [127:0] ec);
      vec_t v;
      v.do_tlr = tl; v.skip_ir = sk; v.op = op; v.n = n; v.pause_at = p;
      v.data = d; v.exp_out = eo; v.exp_err = ee; v.exp_upd = eu; v.exp_cfg = ec;
      return v;
   endfunction

   initial begin
      logic [IRW-1:0] ircap;
      logic [63:0] out;
      logic [63:0] eo;
      logic [3:0]  upd;
      logic [3:0]  eu;
      logic        o;
      logic [127:0] c1;
      logic [127:0] c2;

      c1 = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
      c2 = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'hCAFE_F00D};
      tv[0]  = mk(1'b0, 1'b1, 30, 32,  0, 64'h0,           64'h0A1C_0288,   1'b0, 4'b0000, 128'h0);
      tv[1]  = mk(1'b0, 1'b0,  3, 32,  0, 64'hDEAD_BEEF,   64'h0,           1'b0, 4'b0010, c1);
      tv[2]  = mk(1'b0, 1'b0,  3, 32,  0, 64'hDEAD_BEEF,   64'hDEAD_BEEF,   1'b0, 4'b0010, c1);
      tv[3]  = mk(1'b0, 1'b0,  1, 31,  0, 64'h7FFF_FFFF,   64'h0,           1'b1, 4'b0000, c1);
      tv[4]  = mk(1'b0, 1'b0, 31,  4,  0, 64'hB,           64'h6,           1'b1, 4'b0000, c1);
      tv[5]  = mk(1'b1, 1'b1, 30, 32,  0, 64'h0,           64'h0A1C_0288,   1'b0, 4'b0000, c1);
      tv[6]  = mk(1'b0, 1'b0,  1, 32, 16, 64'hCAFE_F00D,   64'h0,           1'b0, 4'b0001, c2);
      tv[7]  = mk(1'b0, 1'b0,  1, 32,  0, 64'hCAFE_F00D,   64'hCAFE_F00D,   1'b0, 4'b0001, c2);
      tv[8]  = mk(1'b0, 1'b0,  4, 32,  0, 64'h0,           64'h1234_5678,   1'b0, 4'b0000, c2);
      tv[9]  = mk(1'b0, 1'b0,  5, 32,  0, 64'hFFFF_FFFF,   64'h0,           1'b0, 4'b0000, c2);
      tv[10] = mk(1'b0, 1'b0,  3,  0,  0, 64'h0,           64'h0,           1'b1, 4'b0000, c2);
      tv[11] = mk(1'b1, 1'b0,  3, 33,  0, 64'h1_0000_0001, 64'h1_DEAD_BEEF, 1'b1, 4'b0000, c2);
      tv[12] = mk(1'b1, 1'b0,  0,  5,  0, 64'h15,          64'h13,          1'b0, 4'b0000, c2);
      tv[13] = mk(1'b0, 1'b0,  9,  3,  0, 64'h5,           64'h2,           1'b0, 4'b0000, c2);

      sts_m[0] = 32'h0BAD_0013;
      sts_m[1] = 32'h5555_0001;
      sts_m[2] = 32'h1234_5678;
      sts_m[3] = 32'hA5A5_0003;
      for (int k = 0; k < NREG; k++) sts_d[k*RW +: RW] = sts_m[k];

      repeat (3) @(posedge tck);
      #1;
      check("rst_jstate",  128'(jstate),  128'(4'b1110));
      check("rst_tdo",     128'(tdo),     128'(1'b0));
      check("rst_tdo_oe",  128'(tdo_oe),  128'(1'b0));
      check("rst_cfg_q",   128'(cfg_q),   128'h0);
      check("rst_cfg_upd", 128'(cfg_upd), 128'(4'b0000));
      check("rst_len_err", 128'(len_err), 128'(1'b0));
      @(negedge tck);
      #2;
      hard_rst = 1'b1;

      for (int t = 0; t < 14; t++) begin
         if (tv[t].do_tlr) tlr_reset();
         if (!tv[t].skip_ir) begin
            ir_scan(IRW'(tv[t].op), ircap);
            check($sformatf("tv%0d_ir_capture", t), 128'(ircap), 128'(5'b00001));
         end
         dr_scan(tv[t].n, tv[t].data, tv[t].pause_at, out, upd);
         check($sformatf("tv%0d_tdo", t), 128'(out & nmask(tv[t].n)),
               128'(tv[t].exp_out & nmask(tv[t].n)));
         check($sformatf("tv%0d_len_err", t), 128'(len_err), 128'(tv[t].exp_err));
         check($sformatf("tv%0d_cfg_upd", t), 128'(upd), 128'(tv[t].exp_upd));
         check($sformatf("tv%0d_cfg_q", t), cfg_q, tv[t].exp_cfg);
         step(1'b0, 1'b0, o);
         check($sformatf("tv%0d_upd_clear", t), 128'(cfg_upd), 128'(4'b0000));
      end

      // Async reset in the middle of a CFG_3 shift: everything drops at once.
      ir_scan(5'd7, ircap);
      step(1'b1, 1'b0, o);
      step(1'b0, 1'b0, o);
      step(1'b0, 1'b0, o);
      for (int i = 0; i < 36; i++) step(1'b0, 1'b1, o);
      check("midscan_tdo_oe", 128'(tdo_oe), 128'(1'b1));
      check("midscan_tdo",    128'(tdo),    128'(1'b1));
      #2;
      hard_rst = 1'b0;
      #1;
      check("hrst_cfg_q",   cfg_q,          128'h0);
      check("hrst_jstate",  128'(jstate),   128'(4'b1110));
      check("hrst_tdo",     128'(tdo),      128'(1'b0));
      check("hrst_tdo_oe",  128'(tdo_oe),   128'(1'b0));
      check("hrst_cfg_upd", 128'(cfg_upd),  128'(4'b0000));
      @(negedge tck);
      #2;
      hard_rst = 1'b1;
      for (int k = 0; k < NREG; k++) cfg_m[k] = 32'h0;
      err_m = 1'b0;

      for (int r = 0; r < 40; r++) begin
         int sel;
         int op;
         int len;
         int n;
         int p;
         logic [63:0] data;
         for (int k = 0; k < NREG; k++) begin
            sts_m[k] = $urandom;
            sts_d[k*RW +: RW] = sts_m[k];
         end
         sel = $urandom_range(0, 11);
         if (sel < 8)       op = sel;
         else if (sel == 8) op = 30;
         else if (sel == 9) op = 31;
         else               op = $urandom_range(8, 29);
         len = (op < 8 || op == 30) ? 32 : 1;
         case ($urandom_range(0, 4))
            0, 1:    n = len;
            2:       n = len + 1;
            3:       n = (len > 1) ? len - 1 : 0;
            default: n = $urandom_range(0, 40);
         endcase
         p = ($urandom_range(0, 1) == 1 && n > 1) ? $urandom_range(1, n - 1) : 0;
         data = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) begin
            tlr_reset();
            err_m = 1'b0;
         end
         ir_scan(IRW'(op), ircap);
         model_scan(op, n, data, eo, eu);
         dr_scan(n, data, p, out, upd);
         check($sformatf("rnd%0d_op%0d_n%0d_tdo", r, op, n), 128'(out & nmask(n)), 128'(eo));
         check($sformatf("rnd%0d_len_err", r), 128'(len_err), 128'(err_m));
         check($sformatf("rnd%0d_cfg_upd", r), 128'(upd), 128'(eu));
         check($sformatf("rnd%0d_cfg_q", r), cfg_q, cfg_flat());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
